imem_fetch_ctrl: RTL and testbench
==================================

// Module: imem_fetch_ctrl
// PURPOSE
//  Fetch sequencer for the byte-wide instruction memory. Reads 4 consecutive bytes per
//  instruction and assembles them big-endian into a 32-bit word with valid/ready handshake
//  to decode. Accepts PC redirects from branch/jump logic.
//  Arbitrates the memory port: a boot loader can take the port over to write program bytes.
// PARAMETERS
//  ADDR_W    5   byte address width; memory depth = 2**ADDR_W bytes
//  RESET_PC  0   fetch start address after reset and after a load session
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       reset, asynchronous, active-low
//  ld_en        in   1       loader owns memory port while high
//  ld_we        in   1       loader byte write strobe (qualified by ld_en)
//  ld_addr      in   ADDR_W  loader byte address
//  ld_data      in   8       loader write byte
//  mem_addr     out  ADDR_W  memory byte address
//  mem_we       out  1       memory write enable
//  mem_wdata    out  8       memory write byte
//  mem_rdata    in   8       memory read byte, combinational from mem_addr (same cycle)
//  redirect     in   1       load new PC, abort current fetch
//  redirect_pc  in   ADDR_W  redirect target (any byte alignment legal)
//  inst         out  32      assembled instruction, {b[pc],b[pc+1],b[pc+2],b[pc+3]}
//  inst_pc      out  ADDR_W  byte address of inst
//  inst_valid   out  1       inst/inst_pc valid
//  inst_ready   in   1       decode accepts when valid&&ready
//  ld_busy      out  1       high in LOAD state
// BEHAVIOUR
//  Reset (rst=0, async): state=FETCH, pc=RESET_PC, cnt=0, inst=0, inst_pc=0, inst_valid=0,
//   mem_we=0, ld_busy=0. Reset mid-operation discards any partial word.
//  States: FETCH, HOLD, LOAD. Priority each cycle: ld_en > redirect > handshake.
//  FETCH: mem_addr=pc+cnt (mod 2**ADDR_W, wraps). Shift mem_rdata into assembly reg MSB-first;
//   cnt++. On the cnt==3 cycle: inst<=assembled word, inst_pc<=pc, inst_valid<=1, ->HOLD.
//   Latency: inst_valid rises at the 4th clock edge after entering FETCH.
//  HOLD: inst, inst_pc stable; mem_addr=pc. On valid&&ready: inst_valid<=0, pc<=pc+4 (wraps),
//   cnt<=0, ->FETCH. Ready without valid is ignored. No prefetch; throughput 1 inst/5 clk.
//  redirect (FETCH or HOLD): pc<=redirect_pc, cnt<=0, inst_valid<=0, partial bytes dropped,
//   ->FETCH. Simultaneous with a HOLD handshake: the handshake completes (instruction consumed);
//   the next pc is redirect_pc, not pc+4.
//  ld_en=1 in any state: ->LOAD next edge, inst_valid<=0, partial fetch aborted. redirect ignored.
//   In LOAD: mem_addr=ld_addr, mem_wdata=ld_data, mem_we=ld_we (combinational, LOAD only).
//   ld_busy=1. On ld_en falling: pc<=RESET_PC, cnt<=0, ->FETCH.
//   In the ld_en-rise cycle, outputs still follow the prior state; mem_we=0 outside LOAD.
//  Widths: pc, cnt adders truncate to ADDR_W / 2 bits; no overflow flag.
// STRUCTURE
//  Shared package imem_pkg: ADDR_W default, BYTES_PER_INST=4, state encoding
//   (FETCH/HOLD/LOAD), RESET_PC default.
//  One natural sub-module: imem_byte_assembler (8->32 shift register, clear, load strobe).
//  FSM, pc/cnt counters and port mux stay in imem_fetch_ctrl.
// TESTING
//  1. Memory bytes 0..3 = FC,20,00,08; release rst, ready=1 -> 4th edge inst=32'hFC200008,
//     inst_pc=0, valid=1; next fetch reads addr 4.
//  2. Hold ready=0 for 3 clk after valid -> inst, inst_pc unchanged, mem_we=0; ready=1 ->
//     consumed once, pc=4.
//  3. redirect_pc=30, bytes 30,31,0,1 = 01,A9,FC,20 -> inst=32'h01A9FC20, inst_pc=30;
//     next inst_pc=2 (wrap).
//  4. Redirect to 8 at cnt==2, then redirect coincident with handshake -> partial word
//     dropped, no valid; next inst_pc=redirect_pc.
//  5. ld_en mid-fetch; write 12,34,56,78 to 0..3; drop ld_en -> valid drops, mem_we follows
//     ld_we; inst=32'h12345678 from pc 0.
//  6. Assert rst low in HOLD and in LOAD -> all outputs immediately at reset values;
//     refetch from RESET_PC.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared constants and state encoding for the instruction-memory fetch controller.
package imem_pkg;
  localparam int unsigned ADDR_W_DEF     = 5;
  localparam int unsigned RESET_PC_DEF   = 0;
  localparam int unsigned BYTES_PER_INST = 4;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_LOAD  = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/imem_byte_assembler.sv
// Collects bytes MSB-first and publishes a big-endian 32-bit word on the load strobe.
module imem_byte_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        shift,
  input  logic        load,
  input  logic [7:0]  din,
  output logic [31:0] word
);
  logic [23:0] asm_q, asm_d;
  logic [31:0] word_q, word_d;

  always_comb begin
    asm_d  = asm_q;
    word_d = word_q;
    if (clr)
      asm_d = '0;
    else if (shift)
      asm_d = {asm_q[15:0], din};
    // The final byte comes straight from the bus, so the word is complete this cycle.
    if (load)
      word_d = {asm_q, din};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      asm_q  <= '0;
      word_q <= '0;
    end else begin
      asm_q  <= asm_d;
      word_q <= word_d;
    end
  end

  assign word = word_q;
endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: assembles 4-byte instructions from a byte-wide memory, handles
// redirects, and hands the memory port to a boot loader while ld_en is high.
module imem_fetch_ctrl
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_en,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic              ld_busy
);
  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic              vld_q, vld_d;
  logic              asm_clr, asm_shift, asm_load;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    inst_pc_d = inst_pc_q;
    vld_d     = vld_q;
    asm_clr   = 1'b0;
    asm_shift = 1'b0;
    asm_load  = 1'b0;
    mem_addr  = pc_q;
    mem_we    = 1'b0;
    mem_wdata = '0;
    ld_busy   = 1'b0;

    case (state_q)
      ST_FETCH: begin
        mem_addr = pc_q + ADDR_W'(cnt_q);
        if (ld_en) begin
          state_d = ST_LOAD;
          vld_d   = 1'b0;
          cnt_d   = '0;
          asm_clr = 1'b1;
        end else if (redirect) begin
          pc_d    = redirect_pc;
          cnt_d   = '0;
          asm_clr = 1'b1;
        end else begin
          asm_shift = 1'b1;
          cnt_d     = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            asm_load  = 1'b1;
            inst_pc_d = pc_q;
            vld_d     = 1'b1;
            state_d   = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (ld_en) begin
          state_d = ST_LOAD;
          vld_d   = 1'b0;
          cnt_d   = '0;
        end else if (redirect) begin
          // A coincident handshake is consumed too; only the next pc differs.
          pc_d    = redirect_pc;
          cnt_d   = '0;
          vld_d   = 1'b0;
          state_d = ST_FETCH;
        end else if (vld_q && inst_ready) begin
          pc_d    = pc_q + ADDR_W'(BYTES_PER_INST);
          cnt_d   = '0;
          vld_d   = 1'b0;
          state_d = ST_FETCH;
        end
      end
      ST_LOAD: begin
        mem_addr  = ld_addr;
        mem_wdata = ld_data;
        mem_we    = ld_we & ld_en;
        ld_busy   = 1'b1;
        if (!ld_en) begin
          pc_d    = ADDR_W'(RESET_PC);
          cnt_d   = '0;
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_FETCH;
        pc_d    = ADDR_W'(RESET_PC);
        cnt_d   = '0;
        vld_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_FETCH;
      pc_q      <= ADDR_W'(RESET_PC);
      cnt_q     <= '0;
      inst_pc_q <= '0;
      vld_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      inst_pc_q <= inst_pc_d;
      vld_q     <= vld_d;
    end
  end

  imem_byte_assembler u_asm (
    .clk   (clk),
    .rst   (rst),
    .clr   (asm_clr),
    .shift (asm_shift),
    .load  (asm_load),
    .din   (mem_rdata),
    .word  (inst)
  );

  assign inst_pc    = inst_pc_q;
  assign inst_valid = vld_q;
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a behavioural 32-byte memory.
module tb_imem_fetch_ctrl;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              ld_en = 1'b0;
  logic              ld_we = 1'b0;
  logic [ADDR_W-1:0] ld_addr = '0;
  logic [7:0]        ld_data = '0;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              redirect = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic [31:0]       inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_valid;
  logic              inst_ready = 1'b0;
  logic              ld_busy;

  logic [7:0] mem [32];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  imem_fetch_ctrl #(.ADDR_W(ADDR_W), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_we(ld_we), .ld_addr(ld_addr),
    .ld_data(ld_data), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .ld_busy(ld_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_inst(input string tag, input logic [31:0] w, input int pc);
    check({tag, "_valid"}, 32'(inst_valid), 32'd1);
    check({tag, "_inst"}, inst, w);
    check({tag, "_pc"}, 32'(inst_pc), 32'(pc));
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_valid"}, 32'(inst_valid), 32'd0);
    check({tag, "_inst"}, inst, 32'd0);
    check({tag, "_pc"}, 32'(inst_pc), 32'd0);
    check({tag, "_we"}, 32'(mem_we), 32'd0);
    check({tag, "_busy"}, 32'(ld_busy), 32'd0);
    check({tag, "_addr"}, 32'(mem_addr), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    mem[0] = 8'hFC; mem[1] = 8'h20; mem[2] = 8'h00; mem[3] = 8'h08;
    mem[4] = 8'h11; mem[5] = 8'h22; mem[6] = 8'h33; mem[7] = 8'h44;
    mem[8] = 8'hA1; mem[9] = 8'hB2; mem[10] = 8'hC3; mem[11] = 8'hD4;
    mem[16] = 8'h5A; mem[17] = 8'h6B; mem[18] = 8'h7C; mem[19] = 8'h8D;
    mem[30] = 8'h01; mem[31] = 8'hA9;

    // 1: reset values, then first instruction on the 4th edge
    tick(2);
    check_reset("rst0");
    inst_ready = 1'b1;
    rst = 1'b1;
    tick(3);
    check("t1_novalid3", 32'(inst_valid), 32'd0);
    tick(1);
    check_inst("t1", 32'hFC200008, 0);
    tick(1);
    check("t1_consumed", 32'(inst_valid), 32'd0);
    check("t1_next_addr", 32'(mem_addr), 32'd4);

    // 2: decode stalls for 3 clocks
    inst_ready = 1'b0;
    tick(4);
    check_inst("t2", 32'h11223344, 4);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check_inst("t2_hold", 32'h11223344, 4);
      check("t2_we", 32'(mem_we), 32'd0);
      check("t2_addr", 32'(mem_addr), 32'd4);
    end
    inst_ready = 1'b1;
    tick(1);
    check("t2_consumed", 32'(inst_valid), 32'd0);
    check("t2_next_addr", 32'(mem_addr), 32'd8);
    inst_ready = 1'b0;

    // 3: redirect to 30, fetch wraps through address 0
    redirect = 1'b1; redirect_pc = 5'd30;
    tick(1);
    redirect = 1'b0;
    check("t3_addr", 32'(mem_addr), 32'd30);
    tick(4);
    check_inst("t3", 32'h01A9FC20, 30);
    inst_ready = 1'b1;
    tick(1);
    inst_ready = 1'b0;
    check("t3_wrap_addr", 32'(mem_addr), 32'd2);
    tick(4);
    check_inst("t3_next", 32'h00081122, 2);

    // 4: redirect mid-word, then redirect with handshake
    inst_ready = 1'b1;
    tick(1);
    inst_ready = 1'b0;
    tick(2);
    check("t4_cnt2_addr", 32'(mem_addr), 32'd8);
    redirect = 1'b1; redirect_pc = 5'd8;
    tick(1);
    redirect = 1'b0;
    check("t4_redir_valid", 32'(inst_valid), 32'd0);
    check("t4_redir_addr", 32'(mem_addr), 32'd8);
    tick(3);
    check("t4_partial_dropped", 32'(inst_valid), 32'd0);
    tick(1);
    check_inst("t4", 32'hA1B2C3D4, 8);
    inst_ready = 1'b1; redirect = 1'b1; redirect_pc = 5'd16;
    tick(1);
    inst_ready = 1'b0; redirect = 1'b0;
    check("t4_hs_valid", 32'(inst_valid), 32'd0);
    check("t4_hs_addr", 32'(mem_addr), 32'd16);
    tick(4);
    check_inst("t4_hs", 32'h5A6B7C8D, 16);

    // 5: loader takes over mid-fetch
    inst_ready = 1'b1;
    tick(1);
    inst_ready = 1'b0;
    tick(2);
    ld_en = 1'b1;
    #1;
    check("t5_rise_busy", 32'(ld_busy), 32'd0);
    check("t5_rise_we", 32'(mem_we), 32'd0);
    check("t5_rise_addr", 32'(mem_addr), 32'd22);
    tick(1);
    check("t5_busy", 32'(ld_busy), 32'd1);
    check("t5_valid", 32'(inst_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      ld_addr = 5'(i);
      ld_data = 8'(8'h12 + 8'(i) * 8'h22);
      ld_we = 1'b1;
      #1;
      check("t5_we", 32'(mem_we), 32'd1);
      check("t5_addr", 32'(mem_addr), 32'(i));
      check("t5_wdata", 32'(mem_wdata), 32'(8'h12 + 8'(i) * 8'h22));
      tick(1);
    end
    ld_we = 1'b0;
    #1;
    check("t5_we_off", 32'(mem_we), 32'd0);
    ld_en = 1'b0;
    tick(1);
    check("t5_busy_off", 32'(ld_busy), 32'd0);
    check("t5_restart_addr", 32'(mem_addr), 32'd0);
    tick(4);
    check_inst("t5", 32'h12345678, 0);

    // 6: asynchronous reset in HOLD and in LOAD
    rst = 1'b0;
    #1;
    check_reset("t6_hold");
    rst = 1'b1;
    tick(4);
    check_inst("t6_refetch", 32'h12345678, 0);
    ld_en = 1'b1;
    tick(1);
    ld_we = 1'b1; ld_addr = 5'd5; ld_data = 8'hEE;
    #1;
    check("t6_load_busy", 32'(ld_busy), 32'd1);
    check("t6_load_we", 32'(mem_we), 32'd1);
    rst = 1'b0;
    #1;
    check_reset("t6_load");
    ld_en = 1'b0; ld_we = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(4);
    check_inst("t6_refetch2", 32'h12345678, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
